// File: rtl/cpu_pkg.sv
// Shared types for the RAM arbiter: FSM states and requester ids.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_LD, REQ_DT, REQ_IF} req_id_t;

  // Wide enough for MAX_CONSEC up to 15.
  localparam int CONSEC_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Fixed-priority pick loader > data > fetch; starve lets a waiting fetch beat data.
// Purely combinational, no backpressure of its own.
module arb_pick
  import cpu_pkg::*;
(
  input  logic    ld_req,
  input  logic    dt_req,
  input  logic    if_req,
  input  logic    starve,
  output req_id_t pick
);

  always_comb begin
    pick = REQ_NONE;
    if (ld_req) begin
      pick = REQ_LD;
    end else if (dt_req && !(if_req && starve)) begin
      pick = REQ_DT;
    end else if (if_req) begin
      pick = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises loader/data/fetch onto one synchronous RAM port, one access at a time.
// Read: gnt +1, rvalid +2, idle +3 cycles; write: gnt +1, idle +2; losers wait with req held.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MAX_CONSEC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic              dt_req,
  input  logic              if_req,
  input  logic              ld_we,
  input  logic              dt_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] dt_wdata,
  output logic              ld_gnt,
  output logic              dt_gnt,
  output logic              if_gnt,
  output logic              ld_rvalid,
  output logic              dt_rvalid,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC);

  arb_state_t          state;
  arb_state_t          state_nxt;
  req_id_t             pick;
  req_id_t             win;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CONSEC_W-1:0] consec;
  logic                starve;
  logic                take;

  assign starve = (consec == MAX_C);
  assign take   = (state == IDLE) && (pick != REQ_NONE);

  arb_pick u_pick (
    .ld_req (ld_req),
    .dt_req (dt_req),
    .if_req (if_req),
    .starve (starve),
    .pick   (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win       <= REQ_NONE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      consec    <= '0;
    end else if (take) begin
      win <= pick;
      case (pick)
        REQ_LD: begin
          lat_we    <= ld_we;
          lat_addr  <= ld_addr;
          lat_wdata <= ld_wdata;
        end
        REQ_DT: begin
          lat_we    <= dt_we;
          lat_addr  <= dt_addr;
          lat_wdata <= dt_wdata;
          // Only data grants taken over a waiting fetch count toward the guard.
          if (if_req) begin
            consec <= starve ? consec : consec + CONSEC_W'(1);
          end else begin
            consec <= '0;
          end
        end
        REQ_IF: begin
          lat_we    <= 1'b0;
          lat_addr  <= if_addr;
          lat_wdata <= '0;
          consec    <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ld_gnt    = 1'b0;
    dt_gnt    = 1'b0;
    if_gnt    = 1'b0;
    ld_rvalid = 1'b0;
    dt_rvalid = 1'b0;
    if_rvalid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rdata     = '0;
    case (state)
      IDLE: begin
        if (pick != REQ_NONE) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        ld_gnt    = (win == REQ_LD);
        dt_gnt    = (win == REQ_DT);
        if_gnt    = (win == REQ_IF);
        state_nxt = lat_we ? IDLE : RESP;
      end
      RESP: begin
        ld_rvalid = (win == REQ_LD);
        dt_rvalid = (win == REQ_DT);
        if_rvalid = (win == REQ_IF);
        rdata     = mem_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_stall = (dt_req && !dt_gnt) || (if_req && !if_gnt);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between three requesters: the program loader, the CPU data (load/store) path and the CPU instruction-fetch path.
- Sits between the cpu core, the loader and the RAM instance.
- Serialises accesses through a small FSM and enforces fixed priority loader > data > fetch.
- A starvation guard ensures fetch always makes progress against back-to-back data traffic.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_CONSEC, 3, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_req, dt_req, if_req  in  1 each  access request per requester (loader/data/fetch).
- ld_we, dt_we  in  1 each  write enable; the fetch path is read-only.
- ld_addr, dt_addr, if_addr  in  ADDR_W each  access address.
- ld_wdata, dt_wdata  in  DATA_W each  write data.
- ld_gnt, dt_gnt, if_gnt  out  1 each  one-cycle accept pulse.
- ld_rvalid, dt_rvalid, if_rvalid  out  1 each  one-cycle read-data-valid pulse.
- rdata  out  DATA_W  shared read data; meaningful only while some *_rvalid is high.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read with mem_en.
- cpu_stall  out  1  high when dt_req or if_req is high and not granted this cycle.

Behaviour:
- Reset: state IDLE, consec counter 0. All gnt, rvalid, mem_en, mem_we are 0. mem_addr, mem_wdata and rdata are 0.
- Reset mid-operation: an in-flight access is abandoned. No gnt or rvalid is produced after rst is sampled high.
- FSM states:
  - IDLE: arbitrate at the clock edge. If any request is high, latch winner id, we, addr and wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_en=1. mem_we, mem_addr and mem_wdata come from the latch. The winner's gnt=1. Next state is RESP for a read, IDLE for a write.
  - RESP: the winner's rvalid=1 and rdata=mem_rdata, driven combinationally from the RAM. Next state IDLE.
- Latency from request sampled in IDLE: read is gnt +1 cycle, rvalid +2 cycles, back in IDLE +3 cycles. Write is gnt +1 cycle, back in IDLE +2 cycles.
- Handshake: a requester holds req, we, addr and wdata stable until its gnt. It deasserts req at the edge ending the gnt cycle unless it issues a new access. Inputs are ignored outside IDLE.
- Priority in IDLE:
  - ld_req always wins.
  - Otherwise dt_req wins, unless if_req is high and consec==MAX_CONSEC, in which case fetch wins.
  - Otherwise if_req wins.
- Consec counter:
  - Increments (saturating at MAX_CONSEC) when data is granted while if_req is high.
  - Clears when fetch is granted or when if_req is low at a data grant.
  - Loader grants leave it unchanged.
- The loader can starve the CPU indefinitely by design. cpu_stall stays high throughout.
- Simultaneous requests from all three: loader first, then data, then fetch (guard permitting). One access at a time; no pipelining.
- Address and data are passed through unchanged. No width conversion.

Decomposition:
- Shared package cpu_pkg:
  - arb_state_t enum: IDLE, ACCESS, RESP.
  - req_id_t enum: REQ_NONE, REQ_LD, REQ_DT, REQ_IF.
- One natural combinational sub-module, arb_pick: takes the three reqs plus a starve flag and returns req_id_t.
- The FSM, latch and counter stay in mem_arbiter.

Test Plan:
- Reset, then idle, with no requests: mem_en=0, all gnt/rvalid=0, cpu_stall=0.
- Single read, RAM[0x0010]=0xA5: if_req with if_addr=0x0010. Expect if_gnt one cycle later, then if_rvalid with rdata=0xA5 on the next cycle, then IDLE.
- Write then read: dt_req with we=1, addr=0x0100, wdata=0x3C. Expect dt_gnt and mem_we=1 with addr 0x0100 and wdata 0x3C. A following dt read of 0x0100 returns 0x3C.
- Three-way contention in the same cycle:
  - Expect grant order loader, data, fetch.
  - ld_gnt first; data and fetch wait with cpu_stall=1.
- Starvation guard with MAX_CONSEC=3: dt_req and if_req held continuously, reads only. Expect grant sequence dt,dt,dt,if,dt,dt,dt,if.
- Reset mid-read: rst high during the ACCESS cycle of a fetch read. Expect no if_rvalid, state IDLE, counter 0. The next request is serviced normally.
